mem_writer_ctrl: RTL and testbench
==================================

MEM_WRITER_CTRL -- requirements
Module: mem_writer_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 1000000, sets the debounce stable-time in clk cycles (20 ms at 50 MHz).
REQ-002 Parameter DB_W, default 20, sets the debounce counter width; it SHALL satisfy 2^DB_W > DB_CYCLES.
REQ-003 Port clk, input, 1, the single system clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-low reset.
REQ-005 Port sw, input, 8, the data byte to be written; asynchronous to clk.
REQ-006 Port btn_wr, input, 1, raw write pushbutton; active-high; asynchronous.
REQ-007 Port btn_inc, input, 1, raw address-increment pushbutton; active-high; asynchronous.
REQ-008 Port btn_dec, input, 1, raw address-decrement pushbutton; active-high; asynchronous.
REQ-009 Port addr, output, 10, address to the 1K x 8 synchronous-read memory.
REQ-010 Port DI, output, 8, write data to the memory.
REQ-011 Port write_enable, output, 1, memory write strobe.
REQ-012 Port DO, input, 8, memory read data; it SHALL be valid one clk after addr is presented.
REQ-013 Port rd_byte, output, 8, the last byte read back from memory, intended for the hex display path.
REQ-014 Port busy, output, 1, high while a write/verify transaction is in progress.
REQ-015 Port err, output, 1, sticky flag indicating a verify mismatch.

Function
REQ-016 Each button input SHALL pass through a 2-FF synchronizer, followed by a debouncer.
REQ-017 The debounced level SHALL change only after the synchronized input has differed from it for DB_CYCLES consecutive cycles.
REQ-018 Each debouncer SHALL emit a one-cycle press event on the rising edge of its debounced level; releases SHALL produce no event.
REQ-019 The FSM SHALL have exactly four states: IDLE, WRITE, RD_WAIT and CHECK.
REQ-020 IDLE: a wr event SHALL register sw into DI and transition to WRITE.
REQ-021 IDLE, no wr event: an inc event SHALL set addr to addr+1 modulo 1024.
REQ-022 IDLE, no wr event: a dec event SHALL set addr to addr-1 modulo 1024.
REQ-023 Wrap-around: inc at addr 1023 SHALL yield 0, and dec at addr 0 SHALL yield 1023.
REQ-024 Simultaneous inc and dec events in the same cycle SHALL leave addr unchanged.
REQ-025 A wr event coincident with an inc or dec event SHALL win; the inc/dec event SHALL be dropped.
REQ-026 WRITE: write_enable SHALL be high for exactly this one cycle, with addr and DI stable; the next state SHALL be RD_WAIT.
REQ-027 RD_WAIT: write_enable SHALL be low and addr held; the next state SHALL be CHECK.
REQ-028 CHECK: DO SHALL be captured into rd_byte.
REQ-029 CHECK: err SHALL be set if DO != DI and cleared if DO == DI.
REQ-030 CHECK: the next state SHALL be IDLE.
REQ-031 busy SHALL be high in WRITE, RD_WAIT and CHECK, and low in IDLE.
REQ-032 Button events arriving while busy SHALL be discarded and not queued.
REQ-033 Total wr-event-to-IDLE latency SHALL be 3 cycles.
REQ-034 In IDLE, addr SHALL be continuously presented, so that rd_byte can track the current location.
REQ-035 In IDLE, rd_byte SHALL be updated from DO one cycle after every addr change.
REQ-036 write_enable SHALL be a registered output and SHALL never be high outside WRITE.
REQ-037 sw SHALL be sampled only at the wr event; later sw changes SHALL NOT affect DI during a transaction.

Reset
REQ-038 reset low SHALL force, asynchronously: state IDLE, addr 0, DI 0, write_enable 0, rd_byte 0, busy 0, err 0.
REQ-039 reset low SHALL clear all synchronizers and debounce counters, and set all debounced levels to 0.
REQ-040 A reset asserted mid-transaction SHALL drop write_enable in the same instant, and no write SHALL occur after reset release.
REQ-041 After reset release, no press event SHALL fire until a button has been stably high for DB_CYCLES cycles.

Verification (bench uses DB_CYCLES=4 and a behavioural 1K x 8 sync-read RAM)
REQ-042 Scenario: addr=0, sw=8'h3C, wr press -> write_enable high for exactly 1 cycle with addr=0 and DI=3C; 3 cycles later busy=0, rd_byte=3C, err=0.
REQ-043 Scenario: addr=0, dec press -> addr=1023; then two inc presses -> addr=1.
REQ-044 Scenario: btn_inc bouncing 0/1 every 2 cycles for 20 cycles, then stable high -> exactly one addr increment.
REQ-045 Scenario: RAM model forced to return 8'hFF while DI=8'h3C -> err=1 after CHECK; a following correct write clears err.
REQ-046 Scenario: inc press landing during busy -> addr unchanged; simultaneous wr and inc press events -> write at the old addr and no increment.
REQ-047 Scenario: reset pulsed low during RD_WAIT -> all outputs at reset values within the same cycle, and no further write_enable.

Source files
------------

// File: rtl/mem_writer_ctrl.sv
//==============================================================================
// Module      : mem_writer_ctrl
// Description : Pushbutton-driven writer for a 1K x 8 synchronous-read memory,
//               with debounced buttons and a write/read-back verify sequence.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_writer_ctrl #(
    parameter int DB_CYCLES = 1000000,
    parameter int DB_W      = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sw,
    input  logic       btn_wr,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [9:0] addr,
    output logic [7:0] DI,
    output logic       write_enable,
    input  logic [7:0] DO,
    output logic [7:0] rd_byte,
    output logic       busy,
    output logic       err
);

    localparam logic [DB_W-1:0] c_CNT_MAX = DB_W'(DB_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WRITE   = 2'd1;
    localparam logic [1:0] c_ST_RD_WAIT = 2'd2;
    localparam logic [1:0] c_ST_CHECK   = 2'd3;

    // Button index: 0 = write, 1 = increment, 2 = decrement
    logic [2:0] w_btn;
    logic [2:0] w_press;
    logic [1:0] r_state;

    assign w_btn = {btn_dec, btn_inc, btn_wr};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_db
            logic            r_sync1;
            logic            r_sync2;
            logic            r_level;
            logic            r_press;
            logic [DB_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_level <= 1'b0;
                    r_press <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_btn[gi];
                    r_sync2 <= r_sync1;
                    r_press <= 1'b0;
                    // Any agreement with the current level restarts the stable-time count
                    if (r_sync2 != r_level) begin
                        if (r_cnt == c_CNT_MAX) begin
                            r_level <= r_sync2;
                            r_press <= r_sync2;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            addr         <= 10'd0;
            DI           <= 8'd0;
            write_enable <= 1'b0;
            rd_byte      <= 8'd0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    rd_byte <= DO;
                    // Write wins over address moves; opposing moves cancel
                    if (w_press[0]) begin
                        DI           <= sw;
                        write_enable <= 1'b1;
                        busy         <= 1'b1;
                        r_state      <= c_ST_WRITE;
                    end else if (w_press[1] && !w_press[2]) begin
                        addr <= addr + 10'd1;
                    end else if (w_press[2] && !w_press[1]) begin
                        addr <= addr - 10'd1;
                    end
                end
                c_ST_WRITE: begin
                    write_enable <= 1'b0;
                    r_state      <= c_ST_RD_WAIT;
                end
                c_ST_RD_WAIT: begin
                    r_state <= c_ST_CHECK;
                end
                c_ST_CHECK: begin
                    rd_byte <= DO;
                    err     <= (DO != DI);
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    write_enable <= 1'b0;
                    busy         <= 1'b0;
                    r_state      <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_writer_ctrl.sv
//==============================================================================
// Module      : tb_mem_writer_ctrl
// Description : Randomized self-checking bench for mem_writer_ctrl with a
//               behavioural 1K x 8 synchronous-read RAM and reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_writer_ctrl;

    localparam int c_DB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] sw = 8'd0;
    logic       btn_wr = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic [9:0] addr;
    logic [7:0] DI, DO, rd_byte;
    logic       write_enable, busy, err;

    mem_writer_ctrl #(.DB_CYCLES(c_DB), .DB_W(3)) u_dut (
        .clk(clk), .reset(reset), .sw(sw),
        .btn_wr(btn_wr), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .addr(addr), .DI(DI), .write_enable(write_enable), .DO(DO),
        .rd_byte(rd_byte), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural read-first synchronous RAM with a preload port and a fault override
    logic [7:0] mem [1024];
    logic       force_ff = 1'b0;
    logic       init_we = 1'b0;
    logic [9:0] init_a = 10'd0;
    logic [7:0] init_d = 8'd0;

    always @(posedge clk) begin
        if (init_we) mem[init_a] <= init_d;
        else if (write_enable) mem[addr] <= DI;
        DO <= force_ff ? 8'hFF : mem[addr];
    end

    int         we_cnt = 0;
    logic [9:0] we_addr = 10'd0;
    logic [7:0] we_di = 8'd0;

    always @(negedge clk) begin
        if (write_enable) begin
            we_cnt  = we_cnt + 1;
            we_addr = addr;
            we_di   = DI;
        end
    end

    // Reference model: memory image, current address, error flag
    logic [7:0] ref_mem [1024];
    int         ref_addr = 0;
    logic       ref_err = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_addr"}, {22'd0, addr}, ref_addr);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, ref_err});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rd"}, {24'd0, rd_byte}, force_ff ? 32'hFF : {24'd0, ref_mem[ref_addr]});
    endtask

    // Hold the chosen buttons long enough to debounce, release, let everything settle
    task automatic press(input bit w, input bit i, input bit d, input logic [7:0] val);
        int c0;
        c0 = we_cnt;
        @(negedge clk);
        sw = val; btn_wr = w; btn_inc = i; btn_dec = d;
        repeat (12) @(negedge clk);
        btn_wr = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);
        chk("we_count", we_cnt - c0, w ? 32'd1 : 32'd0);
        if (w) begin
            chk("we_addr", {22'd0, we_addr}, ref_addr);
            chk("we_di", {24'd0, we_di}, {24'd0, val});
            ref_mem[ref_addr] = val;
            ref_err = force_ff ? (val != 8'hFF) : 1'b0;
        end else if (i && !d) begin
            ref_addr = (ref_addr + 1) % 1024;
        end else if (d && !i) begin
            ref_addr = (ref_addr + 1023) % 1024;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        int c0;
        int op;
        logic [7:0] v;

        // Preload RAM and model while reset is held
        for (int a = 0; a < 1024; a++) begin
            @(negedge clk);
            v = 8'($urandom);
            init_we = 1'b1; init_a = 10'(a); init_d = v;
            ref_mem[a] = v;
        end
        @(negedge clk);
        init_we = 1'b0;
        chk("rst_addr", {22'd0, addr}, 32'd0);
        chk("rst_di", {24'd0, DI}, 32'd0);
        chk("rst_we", {31'd0, write_enable}, 32'd0);
        chk("rst_rd", {24'd0, rd_byte}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_state("post_rst");

        // Single write with exact strobe/latency timing and sw changing mid-transaction
        sw = 8'h3C; btn_wr = 1'b1;
        k = 0;
        while (!write_enable && k < 40) begin @(negedge clk); k++; end
        chk("s42_we_hi", {31'd0, write_enable}, 32'd1);
        chk("s42_addr", {22'd0, addr}, 32'd0);
        chk("s42_di", {24'd0, DI}, 32'h3C);
        sw = 8'hA5; btn_wr = 1'b0;
        @(negedge clk);
        chk("s42_we_lo", {31'd0, write_enable}, 32'd0);
        chk("s42_busy1", {31'd0, busy}, 32'd1);
        chk("s42_di_hold", {24'd0, DI}, 32'h3C);
        @(negedge clk);
        chk("s42_busy2", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("s42_busy3", {31'd0, busy}, 32'd0);
        chk("s42_rd", {24'd0, rd_byte}, 32'h3C);
        chk("s42_err", {31'd0, err}, 32'd0);
        ref_mem[0] = 8'h3C;
        repeat (12) @(negedge clk);
        check_state("s42_settle");

        // Wrap-around both directions
        press(1'b0, 1'b0, 1'b1, 8'h00);
        check_state("s43_dec");
        press(1'b0, 1'b1, 1'b0, 8'h00);
        check_state("s43_inc1");
        press(1'b0, 1'b1, 1'b0, 8'h00);
        check_state("s43_inc2");

        // Bouncing increment button settles to a single step
        @(negedge clk);
        repeat (10) begin
            btn_inc = ~btn_inc;
            repeat (2) @(negedge clk);
        end
        btn_inc = 1'b1;
        repeat (12) @(negedge clk);
        btn_inc = 1'b0;
        repeat (12) @(negedge clk);
        ref_addr = (ref_addr + 1) % 1024;
        check_state("s44_bounce");

        // Verify mismatch sets err, a clean write clears it
        force_ff = 1'b1;
        press(1'b1, 1'b0, 1'b0, 8'h3C);
        check_state("s45_bad");
        force_ff = 1'b0;
        press(1'b1, 1'b0, 1'b0, 8'h5A);
        check_state("s45_good");

        // Increment landing while busy is dropped
        c0 = we_cnt;
        @(negedge clk);
        sw = 8'h77; btn_wr = 1'b1;
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (12) @(negedge clk);
        btn_wr = 1'b0; btn_inc = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);
        chk("s46_we_count", we_cnt - c0, 32'd1);
        ref_mem[ref_addr] = 8'h77;
        ref_err = 1'b0;
        check_state("s46_busy_inc");
        press(1'b1, 1'b1, 1'b0, 8'h99);
        check_state("s46_simul");

        // Reset during RD_WAIT
        press(1'b0, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        sw = 8'hC3; btn_wr = 1'b1;
        k = 0;
        while (!write_enable && k < 40) begin @(negedge clk); k++; end
        chk("s47_we_hi", {31'd0, write_enable}, 32'd1);
        btn_wr = 1'b0;
        @(posedge clk);
        #1;
        chk("s47_rdwait_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("s47_addr", {22'd0, addr}, 32'd0);
        chk("s47_di", {24'd0, DI}, 32'd0);
        chk("s47_we", {31'd0, write_enable}, 32'd0);
        chk("s47_rd", {24'd0, rd_byte}, 32'd0);
        chk("s47_busy", {31'd0, busy}, 32'd0);
        chk("s47_err", {31'd0, err}, 32'd0);
        ref_mem[ref_addr] = 8'hC3;
        ref_addr = 0;
        ref_err = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        c0 = we_cnt;
        repeat (20) @(negedge clk);
        chk("s47_no_we", we_cnt - c0, 32'd0);
        check_state("s47_after");

        // A press shorter than the stable time produces no event
        btn_inc = 1'b1;
        repeat (3) @(negedge clk);
        btn_inc = 1'b0;
        repeat (12) @(negedge clk);
        check_state("short_press");

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 5));
            v = 8'($urandom);
            force_ff = (op >= 2 && op != 3) && ($urandom_range(0, 5) == 0);
            case (op)
                0: press(1'b0, 1'b1, 1'b0, v);
                1: press(1'b0, 1'b0, 1'b1, v);
                2: press(1'b1, 1'b0, 1'b0, v);
                3: press(1'b0, 1'b1, 1'b1, v);
                4: press(1'b1, 1'b1, 1'b0, v);
                default: press(1'b1, 1'b0, 1'b1, v);
            endcase
            check_state("rand");
            force_ff = 1'b0;
            repeat (4) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
